// File: rtl/store_rmw_unit.sv
// Store narrowing unit: writes sb/sh/sw into a word-wide memory without byte enables.
// Sub-word stores read the containing word, merge the new bytes (big-endian lanes) and write it back.
module store_rmw_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wack,
    output logic              done,
    output logic              misalign,
    output logic              busy
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [1:0]        r_size;
    logic [1:0]        r_off;
    logic [31:0]       r_wdata;
    logic              w_accept;
    logic              w_bad;
    logic [31:0]       w_merged;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        case (req_size)
            SZ_B:    w_bad = 1'b0;
            SZ_H:    w_bad = req_addr[0];
            SZ_W:    w_bad = |req_addr[1:0];
            default: w_bad = 1'b1;
        endcase
    end

    // Offset 0 is the most significant lane of the word.
    always_comb begin
        w_merged = mem_rdata;
        if (r_size == SZ_B) begin
            case (r_off)
                2'd0:    w_merged[31:24] = r_data[7:0];
                2'd1:    w_merged[23:16] = r_data[7:0];
                2'd2:    w_merged[15:8]  = r_data[7:0];
                default: w_merged[7:0]   = r_data[7:0];
            endcase
        end else if (r_off[1]) begin
            w_merged[15:0] = r_data[15:0];
        end else begin
            w_merged[31:16] = r_data[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        misalign  = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (w_bad)                 w_next = S_ERR;
                    else if (req_size == SZ_W) w_next = S_WR;
                    else                       w_next = S_RD;
                end
            end
            S_RD: begin
                mem_rd = 1'b1;
                if (mem_rvalid) w_next = S_WR;
            end
            S_WR: begin
                mem_wr = 1'b1;
                if (mem_wack) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                misalign = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_size  <= '0;
            r_off   <= '0;
            r_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                r_data <= req_wdata;
                r_size <= req_size;
                r_off  <= req_addr[1:0];
                if (!w_bad && req_size == SZ_W) r_wdata <= req_wdata;
            end
            if (r_state == S_RD && mem_rvalid) r_wdata <= w_merged;
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit: inputs driven and outputs sampled on the falling edge.
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_wack = 1'b0;
    logic        done;
    logic        misalign;
    logic        busy;

    int checks = 0;
    int failures = 0;

    int n_rd, n_wr, n_done, n_mis, n_rdy, n_both, n_unst, end_cyc;
    logic [31:0] wd_seen, ad_seen;

    store_rmw_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_wack(mem_wack),
        .done(done), .misalign(misalign), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a falling edge in IDLE; the request is accepted at the next rising edge.
    // Runs until the done or misalign cycle; rvalid/wack come after rdly/wdly wait cycles.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                             input logic [31:0] rd, input int rdly, input int wdly, input bit hold);
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_size = sz;
        mem_rdata = rd; mem_rvalid = 1'b0; mem_wack = 1'b0;
        n_rd = 0; n_wr = 0; n_done = 0; n_mis = 0; n_rdy = 0; n_both = 0; n_unst = 0;
        end_cyc = 0; wd_seen = 'x; ad_seen = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            req_valid = hold;
            if (mem_rd && mem_wr) n_both++;
            if (req_ready) n_rdy++;
            if (mem_rd) begin
                n_rd++;
                ad_seen = mem_addr;
            end
            if (mem_wr) begin
                if (n_wr > 0 && (mem_wdata !== wd_seen || mem_addr !== ad_seen)) n_unst++;
                n_wr++;
                wd_seen = mem_wdata;
                ad_seen = mem_addr;
            end
            mem_rvalid = mem_rd && (n_rd == rdly + 1);
            mem_wack   = mem_wr && (n_wr == wdly + 1);
            if (done) n_done++;
            if (misalign) n_mis++;
            if (done || misalign) begin
                end_cyc = c;
                break;
            end
        end
        mem_rvalid = 1'b0;
        mem_wack = 1'b0;
    endtask

    task automatic chk_idle_after(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_pulse"}, {30'd0, done, misalign}, 32'd0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_strobes", {28'd0, mem_rd, mem_wr, done, misalign}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // sw, zero-wait
        run_store(32'h10, 32'hDEADBEEF, 2'b10, 32'h0, 0, 0, 1'b0);
        chk("sw_nrd", n_rd, 0);
        chk("sw_nwr", n_wr, 1);
        chk("sw_addr", ad_seen, 32'h10);
        chk("sw_wdata", wd_seen, 32'hDEADBEEF);
        chk("sw_done_cyc", end_cyc, 2);
        chk("sw_ndone", n_done, 1);
        chk_idle_after("sw_idle");

        // sb offset 3 -> lowest byte lane
        run_store(32'h13, 32'h123456AB, 2'b00, 32'h11223344, 0, 0, 1'b0);
        chk("sb3_addr", ad_seen, 32'h10);
        chk("sb3_wdata", wd_seen, 32'h112233AB);
        chk("sb3_nrd", n_rd, 1);
        chk("sb3_done_cyc", end_cyc, 3);
        chk("sb3_ndone", n_done, 1);
        chk_idle_after("sb3_idle");

        // sh offset 2 with wait states
        run_store(32'h22, 32'hFFFFCAFE, 2'b01, 32'hAAAABBBB, 3, 2, 1'b0);
        chk("sh_nrd", n_rd, 4);
        chk("sh_nwr", n_wr, 3);
        chk("sh_wdata", wd_seen, 32'hAAAACAFE);
        chk("sh_addr", ad_seen, 32'h20);
        chk("sh_ready_low", n_rdy, 0);
        chk("sh_both", n_both, 0);
        chk("sh_stable", n_unst, 0);
        chk("sh_ndone", n_done, 1);
        chk_idle_after("sh_idle");

        // Rejected requests
        run_store(32'h21, 32'h0, 2'b01, 32'h0, 0, 0, 1'b0);
        chk("e_sh_mis", n_mis, 1);
        chk("e_sh_mem", n_rd + n_wr + n_done, 0);
        chk("e_sh_cyc", end_cyc, 1);
        chk_idle_after("e_sh_idle");
        run_store(32'h22, 32'h0, 2'b10, 32'h0, 0, 0, 1'b0);
        chk("e_sw_mis", n_mis, 1);
        chk("e_sw_mem", n_rd + n_wr + n_done, 0);
        chk("e_sw_cyc", end_cyc, 1);
        chk_idle_after("e_sw_idle");
        run_store(32'h20, 32'h0, 2'b11, 32'h0, 0, 0, 1'b0);
        chk("e_sz_mis", n_mis, 1);
        chk("e_sz_mem", n_rd + n_wr + n_done, 0);
        chk("e_sz_cyc", end_cyc, 1);
        chk_idle_after("e_sz_idle");

        // Asynchronous reset during a WR wait
        req_valid = 1'b1; req_addr = 32'h30; req_wdata = 32'h55AA55AA; req_size = 2'b10;
        mem_wack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("ar_wr1", {31'd0, mem_wr}, 32'd1);
        @(negedge clk);
        chk("ar_wr2", {31'd0, mem_wr}, 32'd1);
        chk("ar_wdata_pre", mem_wdata, 32'h55AA55AA);
        rst_n = 1'b0;
        #1;
        chk("ar_wr_drop", {31'd0, mem_wr}, 32'd0);
        chk("ar_busy_drop", {31'd0, busy}, 32'd0);
        chk("ar_wdata_drop", mem_wdata, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("ar_done_hold", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ready", {31'd0, req_ready}, 32'd1);
        chk("ar_done_after", {31'd0, done}, 32'd0);
        run_store(32'h40, 32'h000000C3, 2'b00, 32'h01020304, 0, 0, 1'b0);
        chk("ar_sb_wdata", wd_seen, 32'hC3020304);
        chk("ar_sb_addr", ad_seen, 32'h40);
        chk("ar_sb_ndone", n_done, 1);
        chk_idle_after("ar_sb_idle");

        // sh offset 0 -> upper half
        run_store(32'h8, 32'h0000BEEF, 2'b01, 32'h12345678, 1, 0, 1'b0);
        chk("sh0_wdata", wd_seen, 32'hBEEF5678);
        chk("sh0_addr", ad_seen, 32'h8);
        chk("sh0_done_cyc", end_cyc, 4);
        chk_idle_after("sh0_idle");

        // Back-to-back with req_valid held
        run_store(32'h0, 32'h000000AA, 2'b00, 32'h11223344, 0, 0, 1'b1);
        chk("bb1_wdata", wd_seen, 32'hAA223344);
        chk("bb1_done_cyc", end_cyc, 3);
        req_addr = 32'h1; req_wdata = 32'h000000BB; mem_rdata = 32'h55667788;
        @(negedge clk);
        chk("bb_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("bb_valid_held", {31'd0, req_valid}, 32'd1);
        run_store(32'h1, 32'h000000BB, 2'b00, 32'h55667788, 0, 0, 1'b0);
        chk("bb2_wdata", wd_seen, 32'h55BB7788);
        chk("bb2_addr", ad_seen, 32'h0);
        chk("bb2_done_cyc", end_cyc, 3);
        chk_idle_after("bb2_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
